// File: rtl/cursor_overlay.sv
// -----------------------------------------------------------------------------
// cursor_overlay
//
// Mouse-cursor overlay stage of the VGA pixel pipeline. It sits between the
// scene drawing stages and the VGA output register. The stage draws an arrow
// sprite, a scope crosshair or nothing at all. The cursor position and mode
// are latched once per frame, on the first cycle of vertical blanking, so the
// cursor cannot tear in the middle of a frame. Every signal passes through
// the same 3-stage pipeline:
//   S1 registers the inputs and the signed offsets dx/dy from the cursor.
//   S2 registers the shape-hit decision and the overlay colour.
//   S3 is the output register.
//
// Ports
//   clk, rst            pixel clock, synchronous active-high reset
//   xpos, ypos          cursor position (arrow tip / scope centre)
//   select_mode         request scope mode
//   hide                suppress the cursor
//   hcount, vcount      pixel counters
//   hsync, vsync        sync timing signals
//   hblnk, vblnk        blanking timing signals
//   rgb_in              upstream pixel colour
//   *_out               the same signals delayed by 3 cycles, with the
//                       cursor overlaid on rgb_out
//   mode_out            current mode: 0 ARROW, 1 SCOPE, 2 HIDDEN
// -----------------------------------------------------------------------------
module cursor_overlay #(
    parameter int               HCNT_W      = 11,
    parameter int               VCNT_W      = 10,
    parameter int               POS_W       = 12,
    parameter int               RGB_W       = 12,
    parameter int               ARROW_N     = 12,
    parameter int               SCOPE_GAP   = 2,
    parameter int               SCOPE_ARM   = 3,
    parameter int               SCOPE_XMAX  = 600,
    parameter logic [RGB_W-1:0] OUTLINE_RGB = 12'h000,
    parameter logic [RGB_W-1:0] FILL_RGB    = 12'hfff,
    parameter logic [RGB_W-1:0] SCOPE_RGB   = 12'h000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [POS_W-1:0]  xpos,
    input  logic [POS_W-1:0]  ypos,
    input  logic              select_mode,
    input  logic              hide,
    input  logic [HCNT_W-1:0] hcount,
    input  logic [VCNT_W-1:0] vcount,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              hblnk,
    input  logic              vblnk,
    input  logic [RGB_W-1:0]  rgb_in,
    output logic [HCNT_W-1:0] hcount_out,
    output logic [VCNT_W-1:0] vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out,
    output logic [1:0]        mode_out
);

    // Offsets are signed and one bit wider than the position, so
    // pixels left of or above the cursor come out negative and never wrap.
    localparam int DW = POS_W + 1;
    localparam int T  = ARROW_N + 5;

    localparam logic signed [DW-1:0] C_ZERO = DW'(0);
    localparam logic signed [DW-1:0] C_ONE  = DW'(1);
    localparam logic signed [DW-1:0] C_N    = DW'(ARROW_N);
    localparam logic signed [DW-1:0] C_NM1  = DW'(ARROW_N - 1);
    localparam logic signed [DW-1:0] C_TM1  = DW'(T - 1);
    localparam logic signed [DW-1:0] C_TMN  = DW'(T - ARROW_N);
    localparam logic signed [DW-1:0] C_TMN1 = DW'(T - ARROW_N - 1);
    localparam logic signed [DW-1:0] C_G1   = DW'(SCOPE_GAP + 1);
    localparam logic signed [DW-1:0] C_GA   = DW'(SCOPE_GAP + SCOPE_ARM);
    localparam logic signed [DW-1:0] C_NG1  = DW'(-(SCOPE_GAP + 1));
    localparam logic signed [DW-1:0] C_NGA  = DW'(-(SCOPE_GAP + SCOPE_ARM));
    localparam logic signed [DW:0]   C_T    = (DW+1)'(T);
    localparam logic [POS_W-1:0]     C_XMAX = POS_W'(SCOPE_XMAX);

    typedef enum logic [1:0] {
        MODE_ARROW  = 2'd0,
        MODE_SCOPE  = 2'd1,
        MODE_HIDDEN = 2'd2
    } mode_e;

    typedef struct packed {
        logic [HCNT_W-1:0] hcount;
        logic [VCNT_W-1:0] vcount;
        logic              hsync;
        logic              vsync;
        logic              hblnk;
        logic              vblnk;
        logic [RGB_W-1:0]  rgb;
    } pix_t;

    // Frame latch and mode state
    logic              fs;
    logic              vblnk_prev_q, vblnk_prev_d;
    logic [POS_W-1:0]  lx_q, lx_d, ly_q, ly_d;
    mode_e             mode_q, mode_d;

    // Pipeline stages
    pix_t                 pix_1_q, pix_1_d;
    logic signed [DW-1:0] dx_1_q, dx_1_d, dy_1_q, dy_1_d;
    mode_e                mode_1_q, mode_1_d;
    pix_t                 pix_2_q, pix_2_d;
    logic                 draw_2_q, draw_2_d;
    logic [RGB_W-1:0]     color_2_q, color_2_d;
    pix_t                 pix_3_q, pix_3_d;

    // Shape-hit terms evaluated in S2
    logic signed [DW:0] sum_s;
    logic               outline_hit;
    logic               fill_hit;
    logic               scope_hit;

    // Frame strobe, per-frame position latch and mode selection
    always_comb begin
        fs           = vblnk & ~vblnk_prev_q;
        vblnk_prev_d = vblnk;
        if (fs) begin
            lx_d = xpos;
            ly_d = ypos;
            if (hide) begin
                mode_d = MODE_HIDDEN;
            end else if (select_mode && (xpos < C_XMAX)) begin
                mode_d = MODE_SCOPE;
            end else begin
                mode_d = MODE_ARROW;
            end
        end else begin
            lx_d   = lx_q;
            ly_d   = ly_q;
            mode_d = mode_q;
        end
    end

    // S1: capture the pixel and compute its offset from the latched cursor
    always_comb begin
        pix_1_d.hcount = hcount;
        pix_1_d.vcount = vcount;
        pix_1_d.hsync  = hsync;
        pix_1_d.vsync  = vsync;
        pix_1_d.hblnk  = hblnk;
        pix_1_d.vblnk  = vblnk;
        pix_1_d.rgb    = rgb_in;
        dx_1_d   = $signed(DW'(hcount)) - $signed(DW'(lx_q));
        dy_1_d   = $signed(DW'(vcount)) - $signed(DW'(ly_q));
        mode_1_d = mode_q;
    end

    // S2: decide whether the pixel lies on the active shape, and its colour
    always_comb begin
        sum_s = (DW+1)'(dx_1_q) + (DW+1)'(dy_1_q);

        // Arrow outline: left edge, diagonal, bottom of the head, tail slope.
        outline_hit = ((dx_1_q == C_ZERO) && (dy_1_q >= C_ZERO) && (dy_1_q <= C_TM1))
                   || ((dx_1_q == dy_1_q) && (dx_1_q >= C_ONE) && (dx_1_q <= C_N))
                   || ((dy_1_q == C_N) && (dx_1_q >= C_TMN) && (dx_1_q <= C_NM1))
                   || ((sum_s == C_T) && (dx_1_q >= C_ONE) && (dx_1_q <= C_TMN1));

        fill_hit = (dx_1_q >= C_ONE) && (dy_1_q > dx_1_q)
                && ((dy_1_q < C_N) || (sum_s < C_T));

        scope_hit = ((dx_1_q == C_ZERO) && (dy_1_q == C_ZERO))
                 || ((dy_1_q == C_ZERO)
                     && (((dx_1_q >= C_G1) && (dx_1_q <= C_GA))
                      || ((dx_1_q <= C_NG1) && (dx_1_q >= C_NGA))))
                 || ((dx_1_q == C_ZERO)
                     && (((dy_1_q >= C_G1) && (dy_1_q <= C_GA))
                      || ((dy_1_q <= C_NG1) && (dy_1_q >= C_NGA))));

        pix_2_d = pix_1_q;
        case (mode_1_q)
            MODE_ARROW: begin
                if (outline_hit) begin
                    draw_2_d  = 1'b1;
                    color_2_d = OUTLINE_RGB;
                end else if (fill_hit) begin
                    draw_2_d  = 1'b1;
                    color_2_d = FILL_RGB;
                end else begin
                    draw_2_d  = 1'b0;
                    color_2_d = '0;
                end
            end
            MODE_SCOPE: begin
                if (scope_hit) begin
                    draw_2_d  = 1'b1;
                    color_2_d = SCOPE_RGB;
                end else begin
                    draw_2_d  = 1'b0;
                    color_2_d = '0;
                end
            end
            MODE_HIDDEN: begin
                draw_2_d  = 1'b0;
                color_2_d = '0;
            end
            default: begin
                draw_2_d  = 1'b0;
                color_2_d = '0;
            end
        endcase
    end

    // S3: overlay the cursor colour, never inside blanking
    always_comb begin
        pix_3_d = pix_2_q;
        if (pix_2_q.hblnk || pix_2_q.vblnk) begin
            pix_3_d.rgb = pix_2_q.rgb;
        end else if (draw_2_q) begin
            pix_3_d.rgb = color_2_q;
        end else begin
            pix_3_d.rgb = pix_2_q.rgb;
        end
    end

    // All state registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            lx_q         <= '0;
            ly_q         <= '0;
            mode_q       <= MODE_ARROW;
            pix_1_q      <= '0;
            dx_1_q       <= '0;
            dy_1_q       <= '0;
            mode_1_q     <= MODE_ARROW;
            pix_2_q      <= '0;
            draw_2_q     <= 1'b0;
            color_2_q    <= '0;
            pix_3_q      <= '0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            lx_q         <= lx_d;
            ly_q         <= ly_d;
            mode_q       <= mode_d;
            pix_1_q      <= pix_1_d;
            dx_1_q       <= dx_1_d;
            dy_1_q       <= dy_1_d;
            mode_1_q     <= mode_1_d;
            pix_2_q      <= pix_2_d;
            draw_2_q     <= draw_2_d;
            color_2_q    <= color_2_d;
            pix_3_q      <= pix_3_d;
        end
    end

    assign hcount_out = pix_3_q.hcount;
    assign vcount_out = pix_3_q.vcount;
    assign hsync_out  = pix_3_q.hsync;
    assign vsync_out  = pix_3_q.vsync;
    assign hblnk_out  = pix_3_q.hblnk;
    assign vblnk_out  = pix_3_q.vblnk;
    assign rgb_out    = pix_3_q.rgb;
    assign mode_out   = mode_q;

endmodule
